// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller at the M stage: holds SR/Cause/EPC, raises the flush request, serves mfc0/mtc0/eret.
// req and Dout are combinational; state updates on the rising edge. No backpressure: req is a one-cycle redirect.
module cp0_exc_ctrl #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter int unsigned IM_W       = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      A1,
  input  logic [4:0]      A2,
  input  logic [31:0]     Din,
  input  logic            we,
  input  logic [31:0]     VPC,
  input  logic            BDIn,
  input  logic [4:0]      ExcCodeIn,
  input  logic [IM_W-1:0] HWInt,
  input  logic            EXLClr,
  output logic            req,
  output logic [31:0]     Dout,
  output logic [31:0]     EPCOut
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;

  logic [IM_W-1:0] sr_im_q, sr_im_d;
  logic            sr_exl_q, sr_exl_d;
  logic            sr_ie_q, sr_ie_d;
  logic            cause_bd_q, cause_bd_d;
  logic [IM_W-1:0] cause_ip_q, cause_ip_d;
  logic [4:0]      cause_exc_q, cause_exc_d;
  logic [31:2]     epc_q, epc_d;

  logic            int_req;
  logic            exc_req;
  logic [31:2]     epc_capture;
  logic            unused_ok;

  assign int_req = (|(HWInt & sr_im_q)) & sr_ie_q & ~sr_exl_q;
  assign exc_req = (ExcCodeIn != 5'd0) & ~sr_exl_q;
  assign req     = reset & (int_req | exc_req);

  // Word-granular subtraction wraps exactly like the 32-bit byte address would.
  assign epc_capture = BDIn ? (VPC[31:2] - 30'd1) : VPC[31:2];

  assign unused_ok = ^{VPC[1:0], HANDLER_PC};

  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_ip_d  = HWInt;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;

    if (req) begin
      sr_exl_d    = 1'b1;
      cause_exc_d = int_req ? 5'd0 : ExcCodeIn;
      cause_bd_d  = BDIn;
      epc_d       = epc_capture;
    end else begin
      if (we) begin
        case (A2)
          REG_SR: begin
            sr_im_d  = Din[10 +: IM_W];
            sr_exl_d = Din[1];
            sr_ie_d  = Din[0];
          end
          REG_EPC: epc_d = Din[31:2];
          default: ;
        endcase
      end
      // eret outranks an mtc0 to SR for the EXL bit.
      if (EXLClr) sr_exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_im_q     <= '0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= 5'd0;
      epc_q       <= '0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  always_comb begin
    Dout = '0;
    case (A1)
      REG_SR: begin
        Dout[10 +: IM_W] = sr_im_q;
        Dout[1]          = sr_exl_q;
        Dout[0]          = sr_ie_q;
      end
      REG_CAUSE: begin
        Dout[31]         = cause_bd_q;
        Dout[10 +: IM_W] = cause_ip_q;
        Dout[6:2]        = cause_exc_q;
      end
      REG_EPC: Dout = {epc_q, 2'b00};
      default: ;
    endcase
  end

  // Bypass lets an eret right behind an mtc0 EPC return to the new address.
  assign EPCOut = (we && (A2 == REG_EPC)) ? {Din[31:2], 2'b00} : {epc_q, 2'b00};

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed vector table, a reset sequence, then random stimulus against a word-level model.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2;
  logic [31:0] Din;
  logic        we;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        req;
  logic [31:0] Dout;
  logic [31:0] EPCOut;

  int n_checks = 0;
  int n_err    = 0;

  cp0_exc_ctrl #(.HANDLER_PC(32'h0000_4180), .IM_W(6)) dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .Din(Din), .we(we),
    .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
    .EXLClr(EXLClr), .req(req), .Dout(Dout), .EPCOut(EPCOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] din;
    logic        we;
    logic [31:0] vpc;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        clr;
    logic        e_req;
    logic [31:0] e_dout;
    logic [31:0] e_epc;
  } vec_t;

  localparam int NV = 34;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic rst, input logic [4:0] a1, input logic [4:0] a2,
                              input logic [31:0] din, input logic w, input logic [31:0] vpc,
                              input logic bd, input logic [4:0] exc, input logic [5:0] hw,
                              input logic clr, input logic e_req, input logic [31:0] e_dout,
                              input logic [31:0] e_epc);
    vec_t v;
    v.rst = rst; v.a1 = a1; v.a2 = a2; v.din = din; v.we = w; v.vpc = vpc;
    v.bd = bd; v.exc = exc; v.hw = hw; v.clr = clr;
    v.e_req = e_req; v.e_dout = e_dout; v.e_epc = e_epc;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    @(negedge clk);
    reset = v.rst; A1 = v.a1; A2 = v.a2; Din = v.din; we = v.we; VPC = v.vpc;
    BDIn = v.bd; ExcCodeIn = v.exc; HWInt = v.hw; EXLClr = v.clr;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Word-level reference state: whole 32-bit register images.
  logic [31:0] m_sr, m_cause, m_epc;

  initial begin
    vec_t v;
    logic        m_irq, m_req;
    logic [31:0] m_dout, m_epco;

    //            rst a1  a2  din           we vpc           bd exc hw     clr req dout          epcout
    vecs[0]  = mk(1, 12, 0,  32'h0,        0, 32'h0,        0, 0,  6'h3F, 0,  0, 32'h0,        32'h0);
    vecs[1]  = mk(1, 13, 0,  32'h0,        0, 32'h0,        0, 0,  6'h00, 0,  0, 32'h0000_FC00, 32'h0);
    vecs[2]  = mk(1, 14, 0,  32'h0,        0, 32'h0,        0, 0,  6'h00, 0,  0, 32'h0,        32'h0);
    vecs[3]  = mk(1, 13, 0,  32'h0,        0, 32'h3010,     0, 12, 6'h00, 0,  1, 32'h0,        32'h0);
    vecs[4]  = mk(1, 13, 0,  32'h0,        0, 32'h3014,     0, 10, 6'h00, 0,  0, 32'h30,       32'h3010);
    vecs[5]  = mk(1, 12, 0,  32'h0,        0, 32'h0,        0, 0,  6'h00, 0,  0, 32'h2,        32'h3010);
    vecs[6]  = mk(1, 14, 0,  32'h0,        0, 32'h0,        0, 0,  6'h00, 1,  0, 32'h3010,     32'h3010);
    vecs[7]  = mk(1, 12, 0,  32'h0,        0, 32'h0,        0, 0,  6'h00, 0,  0, 32'h0,        32'h3010);
    vecs[8]  = mk(1, 12, 0,  32'h0,        0, 32'h3024,     1, 10, 6'h00, 0,  1, 32'h0,        32'h3010);
    vecs[9]  = mk(1, 13, 0,  32'h0,        0, 32'h0,        0, 0,  6'h00, 0,  0, 32'h8000_0028, 32'h3020);
    vecs[10] = mk(1, 14, 0,  32'h0,        0, 32'h0,        0, 0,  6'h00, 0,  0, 32'h3020,     32'h3020);
    vecs[11] = mk(1, 12, 12, 32'h401,      1, 32'h0,        0, 0,  6'h00, 0,  0, 32'h2,        32'h3020);
    vecs[12] = mk(1, 12, 0,  32'h0,        0, 32'h3203,     0, 4,  6'h01, 0,  1, 32'h401,      32'h3020);
    vecs[13] = mk(1, 13, 0,  32'h0,        0, 32'h0,        0, 0,  6'h00, 0,  0, 32'h400,      32'h3200);
    vecs[14] = mk(1, 12, 0,  32'h0,        0, 32'h0,        0, 0,  6'h00, 1,  0, 32'h403,      32'h3200);
    vecs[15] = mk(1, 12, 0,  32'h0,        0, 32'h0,        0, 0,  6'h02, 0,  0, 32'h401,      32'h3200);
    vecs[16] = mk(1, 13, 0,  32'h0,        0, 32'h0,        0, 0,  6'h02, 0,  0, 32'h800,      32'h3200);
    vecs[17] = mk(1, 14, 14, 32'h5000,     1, 32'h3100,     0, 8,  6'h00, 0,  1, 32'h3200,     32'h5000);
    vecs[18] = mk(1, 14, 0,  32'h0,        0, 32'h0,        0, 0,  6'h00, 0,  0, 32'h3100,     32'h3100);
    vecs[19] = mk(1, 13, 13, 32'hFFFF_FFFF, 1, 32'h0,       0, 0,  6'h00, 0,  0, 32'h20,       32'h3100);
    vecs[20] = mk(1, 13, 0,  32'h0,        0, 32'h0,        0, 0,  6'h00, 0,  0, 32'h20,       32'h3100);
    vecs[21] = mk(1, 14, 14, 32'h3047,     1, 32'h0,        0, 0,  6'h00, 1,  0, 32'h3100,     32'h3044);
    vecs[22] = mk(1, 14, 0,  32'h0,        0, 32'h0,        0, 0,  6'h00, 0,  0, 32'h3044,     32'h3044);
    vecs[23] = mk(1, 12, 0,  32'h0,        0, 32'h0,        0, 0,  6'h00, 0,  0, 32'h401,      32'h3044);
    vecs[24] = mk(1, 12, 0,  32'h0,        0, 32'h0,        1, 4,  6'h00, 0,  1, 32'h401,      32'h3044);
    vecs[25] = mk(1, 14, 0,  32'h0,        0, 32'h0,        0, 0,  6'h00, 0,  0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    vecs[26] = mk(1, 13, 0,  32'h0,        0, 32'h0,        0, 0,  6'h00, 0,  0, 32'h8000_0010, 32'hFFFF_FFFC);
    vecs[27] = mk(1, 5,  0,  32'h0,        0, 32'h0,        0, 0,  6'h00, 0,  0, 32'h0,        32'hFFFF_FFFC);
    vecs[28] = mk(1, 0,  12, 32'hFFFF_FFFF, 1, 32'h0,       0, 0,  6'h00, 0,  0, 32'h0,        32'hFFFF_FFFC);
    vecs[29] = mk(1, 12, 0,  32'h0,        0, 32'h0,        0, 0,  6'h00, 0,  0, 32'hFC03,     32'hFFFF_FFFC);
    vecs[30] = mk(1, 12, 0,  32'h0,        0, 32'h0,        0, 0,  6'h00, 1,  0, 32'hFC03,     32'hFFFF_FFFC);
    vecs[31] = mk(0, 12, 0,  32'h0,        0, 32'h0,        0, 12, 6'h3F, 0,  0, 32'hFC01,     32'hFFFF_FFFC);
    vecs[32] = mk(1, 12, 0,  32'h0,        0, 32'h0,        0, 0,  6'h3F, 0,  0, 32'h0,        32'h0);
    vecs[33] = mk(1, 13, 0,  32'h0,        0, 32'h0,        0, 0,  6'h3F, 0,  0, 32'h0000_FC00, 32'h0);

    // Reset held two cycles with interrupts and an exception pending.
    for (int i = 0; i < 2; i++) begin
      apply(mk(0, 12, 0, 32'h0, 0, 32'h0, 0, 12, 6'h3F, 0, 0, 32'h0, 32'h0));
      chk($sformatf("reset_req[%0d]", i), {31'b0, req}, 32'h0);
    end

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
      chk($sformatf("vec%0d_req", i),  {31'b0, req}, {31'b0, vecs[i].e_req});
      chk($sformatf("vec%0d_dout", i), Dout,         vecs[i].e_dout);
      chk($sformatf("vec%0d_epc", i),  EPCOut,       vecs[i].e_epc);
    end

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: v.a1 = 5'd12;
        1: v.a1 = 5'd13;
        2: v.a1 = 5'd14;
        default: v.a1 = 5'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: v.a2 = 5'd12;
        1: v.a2 = 5'd13;
        2: v.a2 = 5'd14;
        default: v.a2 = 5'($urandom);
      endcase
      v.rst = (i == 0) ? 1'b0 : ($urandom_range(0, 99) >= 2);
      v.din = $urandom;
      v.we  = ($urandom_range(0, 99) < 30);
      v.vpc = $urandom;
      v.bd  = 1'($urandom);
      v.exc = ($urandom_range(0, 99) < 20) ? 5'($urandom_range(1, 31)) : 5'd0;
      v.hw  = ($urandom_range(0, 1) == 1) ? 6'($urandom) : 6'd0;
      v.clr = ($urandom_range(0, 99) < 20);
      apply(v);

      m_irq  = (|(v.hw & m_sr[15:10])) & m_sr[0] & ~m_sr[1];
      m_req  = v.rst & (m_irq | ((v.exc != 0) & ~m_sr[1]));
      m_dout = (v.a1 == 12) ? m_sr : (v.a1 == 13) ? m_cause : (v.a1 == 14) ? m_epc : 32'h0;
      m_epco = (v.we && v.a2 == 14) ? (v.din & 32'hFFFF_FFFC) : m_epc;

      chk($sformatf("rnd%0d_req", i), {31'b0, req}, {31'b0, m_req});
      if (i > 0) begin
        chk($sformatf("rnd%0d_dout", i), Dout,   m_dout);
        chk($sformatf("rnd%0d_epc", i),  EPCOut, m_epco);
      end

      @(posedge clk);
      if (!v.rst) begin
        m_sr = 0; m_cause = 0; m_epc = 0;
      end else begin
        m_cause[15:10] = v.hw;
        if (m_req) begin
          m_sr[1]       = 1'b1;
          m_cause[6:2]  = m_irq ? 5'd0 : v.exc;
          m_cause[31]   = v.bd;
          m_epc         = (v.vpc & 32'hFFFF_FFFC) - (v.bd ? 32'd4 : 32'd0);
        end else begin
          if (v.we && v.a2 == 12) m_sr = v.din & 32'h0000_FC03;
          if (v.we && v.a2 == 14) m_epc = v.din & 32'hFFFF_FFFC;
          if (v.clr) m_sr[1] = 1'b0;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
